// File: rtl/resp_rdata_mux_2to1.sv
// resp_rdata_mux_2to1
// Return-path merge for router_slave: folds the read-data (R) and write-
// response (B) channels of two slaves onto one master port. Each channel
// owns a round-robin arbiter with a grant lock, so an R burst is never
// interleaved with another and a B beat is never split. The grant is
// registered: one idle (bubble) cycle separates consecutive grants.

module resp_rdata_mux_2to1 #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,

  // R channel, slave 1
  input  logic [ID_W-1:0]   rid_s1,
  input  logic [DATA_W-1:0] rdata_s1,
  input  logic [1:0]        rresp_s1,
  input  logic              rlast_s1,
  input  logic              rvalid_s1,
  output logic              rready_s1,

  // R channel, slave 2
  input  logic [ID_W-1:0]   rid_s2,
  input  logic [DATA_W-1:0] rdata_s2,
  input  logic [1:0]        rresp_s2,
  input  logic              rlast_s2,
  input  logic              rvalid_s2,
  output logic              rready_s2,

  // R channel, master
  output logic [ID_W-1:0]   rid_m,
  output logic [DATA_W-1:0] rdata_m,
  output logic [1:0]        rresp_m,
  output logic              rlast_m,
  output logic              rvalid_m,
  input  logic              rready_m,

  // B channel, slave 1
  input  logic [ID_W-1:0]   bid_s1,
  input  logic [1:0]        bresp_s1,
  input  logic              bvalid_s1,
  output logic              bready_s1,

  // B channel, slave 2
  input  logic [ID_W-1:0]   bid_s2,
  input  logic [1:0]        bresp_s2,
  input  logic              bvalid_s2,
  output logic              bready_s2,

  // B channel, master
  output logic [ID_W-1:0]   bid_m,
  output logic [1:0]        bresp_m,
  output logic              bvalid_m,
  input  logic              bready_m
);

  // Grant states shared by both channel arbiters.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_S1 = 2'd1;
  localparam logic [1:0] GNT_S2 = 2'd2;

  // prio = 0 prefers slave 1 when both request, prio = 1 prefers slave 2.
  logic [1:0] r_state, r_state_nxt;
  logic       r_prio,  r_prio_nxt;
  logic [1:0] b_state, b_state_nxt;
  logic       b_prio,  b_prio_nxt;

  // Handshake qualifiers for the currently granted slave.
  logic r_done_s1, r_done_s2;
  logic b_done_s1, b_done_s2;

  assign r_done_s1 = rvalid_s1 & rready_m & rlast_s1;
  assign r_done_s2 = rvalid_s2 & rready_m & rlast_s2;
  assign b_done_s1 = bvalid_s1 & bready_m;
  assign b_done_s2 = bvalid_s2 & bready_m;

  // ---------------------------------------------------------------------------
  // R channel
  // ---------------------------------------------------------------------------

  // R arbiter: pick a slave from IDLE, hold it until the rlast handshake.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    r_state_nxt = r_state;
    r_prio_nxt  = r_prio;
    case (r_state)
      IDLE: begin
        if (rvalid_s1 && (!rvalid_s2 || !r_prio)) begin
          r_state_nxt = GNT_S1;
        end else if (rvalid_s2) begin
          r_state_nxt = GNT_S2;
        end
      end
      GNT_S1: begin
        if (r_done_s1) begin
          r_state_nxt = IDLE;
          r_prio_nxt  = 1'b1;
        end
      end
      GNT_S2: begin
        if (r_done_s2) begin
          r_state_nxt = IDLE;
          r_prio_nxt  = 1'b0;
        end
      end
      default: begin
        r_state_nxt = IDLE;
      end
    endcase
  end

  // R arbiter state and priority registers; reset aborts any burst.
  always_ff @(posedge aclk or negedge areset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the values from before the edge, independent of block ordering.
    if (!areset) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_prio  <= r_prio_nxt;
    end
  end

  // R datapath: forward the granted slave, everything else held at zero.
  always_comb begin
    rid_m     = '0;
    rdata_m   = '0;
    rresp_m   = '0;
    rlast_m   = 1'b0;
    rvalid_m  = 1'b0;
    rready_s1 = 1'b0;
    rready_s2 = 1'b0;
    case (r_state)
      GNT_S1: begin
        rid_m     = rid_s1;
        rdata_m   = rdata_s1;
        rresp_m   = rresp_s1;
        rlast_m   = rlast_s1;
        rvalid_m  = rvalid_s1;
        rready_s1 = rready_m;
      end
      GNT_S2: begin
        rid_m     = rid_s2;
        rdata_m   = rdata_s2;
        rresp_m   = rresp_s2;
        rlast_m   = rlast_s2;
        rvalid_m  = rvalid_s2;
        rready_s2 = rready_m;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // B channel
  // ---------------------------------------------------------------------------

  // B arbiter: same policy as R, but every response is a single beat.
  always_comb begin
    b_state_nxt = b_state;
    b_prio_nxt  = b_prio;
    case (b_state)
      IDLE: begin
        if (bvalid_s1 && (!bvalid_s2 || !b_prio)) begin
          b_state_nxt = GNT_S1;
        end else if (bvalid_s2) begin
          b_state_nxt = GNT_S2;
        end
      end
      GNT_S1: begin
        if (b_done_s1) begin
          b_state_nxt = IDLE;
          b_prio_nxt  = 1'b1;
        end
      end
      GNT_S2: begin
        if (b_done_s2) begin
          b_state_nxt = IDLE;
          b_prio_nxt  = 1'b0;
        end
      end
      default: begin
        b_state_nxt = IDLE;
      end
    endcase
  end

  // B arbiter state and priority registers.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      b_state <= IDLE;
      b_prio  <= 1'b0;
    end else begin
      b_state <= b_state_nxt;
      b_prio  <= b_prio_nxt;
    end
  end

  // B datapath: forward the granted slave, everything else held at zero.
  always_comb begin
    bid_m     = '0;
    bresp_m   = '0;
    bvalid_m  = 1'b0;
    bready_s1 = 1'b0;
    bready_s2 = 1'b0;
    case (b_state)
      GNT_S1: begin
        bid_m     = bid_s1;
        bresp_m   = bresp_s1;
        bvalid_m  = bvalid_s1;
        bready_s1 = bready_m;
      end
      GNT_S2: begin
        bid_m     = bid_s2;
        bresp_m   = bresp_s2;
        bvalid_m  = bvalid_s2;
        bready_s2 = bready_m;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_resp_rdata_mux_2to1.sv
// tb_resp_rdata_mux_2to1
// Directed scenarios followed by a randomized traffic phase. A transaction-
// level model (owner slave number and preferred slave number per channel)
// predicts the master-side view every cycle; a per-slave scoreboard checks
// that every generated beat reaches the master once and in order.

module tb_resp_rdata_mux_2to1;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;

  logic              aclk;
  logic              areset;

  logic [ID_W-1:0]   rid_s1, rid_s2, rid_m;
  logic [DATA_W-1:0] rdata_s1, rdata_s2, rdata_m;
  logic [1:0]        rresp_s1, rresp_s2, rresp_m;
  logic              rlast_s1, rlast_s2, rlast_m;
  logic              rvalid_s1, rvalid_s2, rvalid_m;
  logic              rready_s1, rready_s2, rready_m;

  logic [ID_W-1:0]   bid_s1, bid_s2, bid_m;
  logic [1:0]        bresp_s1, bresp_s2, bresp_m;
  logic              bvalid_s1, bvalid_s2, bvalid_m;
  logic              bready_s1, bready_s2, bready_m;

  resp_rdata_mux_2to1 #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .rid_s1    (rid_s1),
    .rdata_s1  (rdata_s1),
    .rresp_s1  (rresp_s1),
    .rlast_s1  (rlast_s1),
    .rvalid_s1 (rvalid_s1),
    .rready_s1 (rready_s1),
    .rid_s2    (rid_s2),
    .rdata_s2  (rdata_s2),
    .rresp_s2  (rresp_s2),
    .rlast_s2  (rlast_s2),
    .rvalid_s2 (rvalid_s2),
    .rready_s2 (rready_s2),
    .rid_m     (rid_m),
    .rdata_m   (rdata_m),
    .rresp_m   (rresp_m),
    .rlast_m   (rlast_m),
    .rvalid_m  (rvalid_m),
    .rready_m  (rready_m),
    .bid_s1    (bid_s1),
    .bresp_s1  (bresp_s1),
    .bvalid_s1 (bvalid_s1),
    .bready_s1 (bready_s1),
    .bid_s2    (bid_s2),
    .bresp_s2  (bresp_s2),
    .bvalid_s2 (bvalid_s2),
    .bready_s2 (bready_s2),
    .bid_m     (bid_m),
    .bresp_m   (bresp_m),
    .bvalid_m  (bvalid_m),
    .bready_m  (bready_m)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Reference model: owning slave number (0 = none) and the slave number that
  // wins when both request.
  int r_owner, r_pref, b_owner, b_pref;
  // Per-cycle observations handed from the check point to the model update.
  logic r_v1, r_v2, r_hs, r_last, b_v1, b_v2, b_hs;
  logic acc_r [2];
  logic acc_b [2];
  int   r_done_src;

  // Scoreboard: beats generated by each slave vs beats seen at the master.
  logic        sb_en;
  logic [38:0] gen_r [2][$];
  logic [38:0] rx_r  [2][$];
  logic [5:0]  gen_b [2][$];
  logic [5:0]  rx_b  [2][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_r(input int s, input logic v, input logic [ID_W-1:0] id,
                       input logic [DATA_W-1:0] d, input logic [1:0] resp, input logic last);
    if (s == 1) begin
      rvalid_s1 = v; rid_s1 = id; rdata_s1 = d; rresp_s1 = resp; rlast_s1 = last;
    end else begin
      rvalid_s2 = v; rid_s2 = id; rdata_s2 = d; rresp_s2 = resp; rlast_s2 = last;
    end
  endtask

  task automatic set_b(input int s, input logic v, input logic [ID_W-1:0] id, input logic [1:0] resp);
    if (s == 1) begin
      bvalid_s1 = v; bid_s1 = id; bresp_s1 = resp;
    end else begin
      bvalid_s2 = v; bid_s2 = id; bresp_s2 = resp;
    end
  endtask

  // Compare the master-side view against what the owning slave presents.
  task automatic model_check();
    logic [41:0] exp_r;
    logic [8:0]  exp_b;
    exp_r = '0;
    exp_b = '0;
    if (r_owner == 1)      exp_r = {rid_s1, rdata_s1, rresp_s1, rlast_s1, rvalid_s1, rready_m, 1'b0};
    else if (r_owner == 2) exp_r = {rid_s2, rdata_s2, rresp_s2, rlast_s2, rvalid_s2, 1'b0, rready_m};
    if (b_owner == 1)      exp_b = {bid_s1, bresp_s1, bvalid_s1, bready_m, 1'b0};
    else if (b_owner == 2) exp_b = {bid_s2, bresp_s2, bvalid_s2, 1'b0, bready_m};
    check("r_chan", {22'd0, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, rready_s1, rready_s2}, {22'd0, exp_r});
    check("b_chan", {55'd0, bid_m, bresp_m, bvalid_m, bready_s1, bready_s2}, {55'd0, exp_b});
    r_v1   = rvalid_s1;
    r_v2   = rvalid_s2;
    r_hs   = ((r_owner == 1 && rvalid_s1) || (r_owner == 2 && rvalid_s2)) && rready_m;
    r_last = (r_owner == 1) ? rlast_s1 : rlast_s2;
    b_v1   = bvalid_s1;
    b_v2   = bvalid_s2;
    b_hs   = ((b_owner == 1 && bvalid_s1) || (b_owner == 2 && bvalid_s2)) && bready_m;
  endtask

  // Apply the arbitration rules at the clock edge.
  task automatic model_update();
    if (r_owner == 0) begin
      if (r_v1 && (!r_v2 || r_pref == 1)) r_owner = 1;
      else if (r_v2)                      r_owner = 2;
    end else if (r_hs && r_last) begin
      r_pref  = (r_owner == 1) ? 2 : 1;
      r_owner = 0;
    end
    if (b_owner == 0) begin
      if (b_v1 && (!b_v2 || b_pref == 1)) b_owner = 1;
      else if (b_v2)                      b_owner = 2;
    end else if (b_hs) begin
      b_pref  = (b_owner == 1) ? 2 : 1;
      b_owner = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model after the rising edge.
  task automatic tick();
    @(negedge aclk);
    model_check();
    acc_r[0]   = rvalid_s1 & rready_s1;
    acc_r[1]   = rvalid_s2 & rready_s2;
    acc_b[0]   = bvalid_s1 & bready_s1;
    acc_b[1]   = bvalid_s2 & bready_s2;
    r_done_src = (rvalid_m && rready_m && rlast_m) ? int'(rdata_m[31:28]) : 0;
    if (sb_en) begin
      if (rvalid_m && rready_m) begin
        if (rdata_m[31:28] == 4'h2) rx_r[1].push_back({rid_m, rdata_m, rresp_m, rlast_m});
        else                        rx_r[0].push_back({rid_m, rdata_m, rresp_m, rlast_m});
      end
      if (bvalid_m && bready_m) begin
        if (bid_m[3]) rx_b[1].push_back({bid_m, bresp_m});
        else          rx_b[0].push_back({bid_m, bresp_m});
      end
    end
    @(posedge aclk);
    model_update();
    #1;
  endtask

  // Asynchronous reset pulse away from the clock edges.
  task automatic apply_reset();
    areset = 1'b0;
    #1;
    check("rst_r_out", {22'd0, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, rready_s1, rready_s2}, 64'd0);
    check("rst_b_out", {55'd0, bid_m, bresp_m, bvalid_m, bready_s1, bready_s2}, 64'd0);
    r_owner = 0; r_pref = 1;
    b_owner = 0; b_pref = 1;
    #1;
    areset = 1'b1;
  endtask

  task automatic clear_inputs();
    set_r(1, 1'b0, '0, '0, 2'b00, 1'b0);
    set_r(2, 1'b0, '0, '0, 2'b00, 1'b0);
    set_b(1, 1'b0, '0, 2'b00);
    set_b(2, 1'b0, '0, 2'b00);
  endtask

  // Random-phase slave driver state, index 0 = slave 1, index 1 = slave 2.
  int                r_left [2];
  int                r_bursts [2];
  int                b_cnt [2];
  logic              rv [2];
  logic              bv [2];
  logic [ID_W-1:0]   rid_c [2];
  logic [DATA_W-1:0] rd_c [2];
  logic [1:0]        rr_c [2];
  logic              rl_c [2];
  logic [ID_W-1:0]   bid_c [2];
  logic [1:0]        br_c [2];

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (rv[i] && acc_r[i]) begin
        rv[i] = 1'b0;
        r_left[i]--;
      end
      if (!rv[i] && r_left[i] == 0 && r_bursts[i] > 0 && $urandom_range(3) != 0) begin
        r_left[i] = $urandom_range(4, 1);
        r_bursts[i]--;
        rid_c[i] = 4'($urandom);
      end
      if (!rv[i] && r_left[i] > 0 && $urandom_range(2) != 0) begin
        rv[i]   = 1'b1;
        rd_c[i] = {4'(i + 1), 28'($urandom)};
        rr_c[i] = 2'($urandom);
        rl_c[i] = (r_left[i] == 1);
        gen_r[i].push_back({rid_c[i], rd_c[i], rr_c[i], rl_c[i]});
      end
      if (bv[i] && acc_b[i]) bv[i] = 1'b0;
      if (!bv[i] && b_cnt[i] > 0 && $urandom_range(2) == 0) begin
        bv[i]    = 1'b1;
        bid_c[i] = {1'(i), 3'($urandom)};
        br_c[i]  = 2'($urandom);
        b_cnt[i]--;
        gen_b[i].push_back({bid_c[i], br_c[i]});
      end
      set_r(i + 1, rv[i], rid_c[i], rd_c[i], rr_c[i], rl_c[i]);
      set_b(i + 1, bv[i], bid_c[i], br_c[i]);
    end
    rready_m = ($urandom_range(3) != 0);
    bready_m = ($urandom_range(3) != 0);
  endtask

  initial begin
    int seq [2];
    int n;
    int exp_src;
    int cyc;
    logic drained;

    areset   = 1'b1;
    sb_en    = 1'b0;
    rready_m = 1'b0;
    bready_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_r[i] = 1'b0;
      acc_b[i] = 1'b0;
    end
    clear_inputs();
    #6;

    // Reset state.
    apply_reset();

    // Single R burst from slave 1: 0x10..0x13, rlast on the fourth beat.
    rready_m = 1'b1;
    bready_m = 1'b1;
    set_r(1, 1'b1, 4'h3, 32'h10, 2'b00, 1'b0);
    #1;
    check("t1_bubble_rvalid", {63'd0, rvalid_m}, 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_r(1, 1'b1, 4'h3, 32'h10 + i, 2'b00, i == 3);
      #1;
      check("t1_rdata", {32'd0, rdata_m}, 64'h10 + i);
      check("t1_rlast", {63'd0, rlast_m}, (i == 3) ? 64'd1 : 64'd0);
      check("t1_rready_s1", {63'd0, rready_s1}, 64'd1);
      check("t1_rready_s2", {63'd0, rready_s2}, 64'd0);
      tick();
    end
    set_r(1, 1'b0, 4'h3, 32'h0, 2'b00, 1'b0);
    #1;
    check("t1_idle_rready_s1", {63'd0, rready_s1}, 64'd0);

    // Simultaneous requests from reset, then continuous 2-beat bursts from
    // both slaves: completed bursts must alternate s1, s2, s1, ...
    apply_reset();
    seq[0]  = 0;
    seq[1]  = 0;
    n       = 0;
    exp_src = 1;
    for (int c = 0; c < 100 && n < 8; c++) begin
      set_r(1, 1'b1, 4'h1, {4'h1, 28'(seq[0])}, 2'b00, (seq[0] % 2) == 1);
      set_r(2, 1'b1, 4'h2, {4'h2, 28'(seq[1])}, 2'b01, (seq[1] % 2) == 1);
      tick();
      if (acc_r[0]) seq[0]++;
      if (acc_r[1]) seq[1]++;
      if (r_done_src != 0) begin
        check("fair_burst_src", 64'(r_done_src), 64'(exp_src));
        exp_src = 3 - exp_src;
        n++;
      end
    end
    check("fair_burst_count", 64'(n), 64'd8);
    clear_inputs();

    // Backpressure mid-burst: payload held, slave not readied, no beat lost.
    apply_reset();
    n = 0;
    rready_m = 1'b1;
    set_r(1, 1'b1, 4'h7, 32'h1000, 2'b00, 1'b0);
    tick(); n += int'(acc_r[0]);
    tick(); n += int'(acc_r[0]);
    set_r(1, 1'b1, 4'h7, 32'hABCD, 2'b00, 1'b0);
    rready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdata", {32'd0, rdata_m}, 64'hABCD);
      check("bp_rready_s1", {63'd0, rready_s1}, 64'd0);
      check("bp_rvalid_m", {63'd0, rvalid_m}, 64'd1);
      tick(); n += int'(acc_r[0]);
    end
    rready_m = 1'b1;
    #1;
    check("bp_release_rready_s1", {63'd0, rready_s1}, 64'd1);
    tick(); n += int'(acc_r[0]);
    set_r(1, 1'b1, 4'h7, 32'h1002, 2'b00, 1'b1);
    tick(); n += int'(acc_r[0]);
    check("bp_beat_count", 64'(n), 64'd3);
    clear_inputs();

    // B response from slave 2 while slave 1 streams an R burst.
    set_r(1, 1'b1, 4'h4, 32'h2000, 2'b00, 1'b0);
    set_b(2, 1'b1, 4'h5, 2'b10);
    tick();
    #1;
    check("rb_bvalid_m", {63'd0, bvalid_m}, 64'd1);
    check("rb_bid_m", {60'd0, bid_m}, 64'd5);
    check("rb_bresp_m", {62'd0, bresp_m}, 64'h2);
    check("rb_bready_s2", {63'd0, bready_s2}, 64'd1);
    check("rb_rdata_beat0", {32'd0, rdata_m}, 64'h2000);
    tick();
    set_b(2, 1'b0, 4'h0, 2'b00);
    for (int i = 1; i < 3; i++) begin
      set_r(1, 1'b1, 4'h4, 32'h2000 + i, 2'b00, i == 2);
      #1;
      check("rb_rdata", {32'd0, rdata_m}, 64'h2000 + i);
      check("rb_bvalid_after", {63'd0, bvalid_m}, 64'd0);
      tick();
    end
    clear_inputs();

    // Reset during beat 2 of a slave 2 burst; slave 1 then wins first.
    apply_reset();
    set_r(2, 1'b1, 4'h9, 32'h3000, 2'b00, 1'b0);
    tick();
    tick();
    set_r(2, 1'b1, 4'h9, 32'h3001, 2'b00, 1'b0);
    set_r(1, 1'b1, 4'hA, 32'h4000, 2'b00, 1'b1);
    #1;
    check("mr_beat2_rdata", {32'd0, rdata_m}, 64'h3001);
    check("mr_s1_ignored", {63'd0, rready_s1}, 64'd0);
    apply_reset();
    tick();
    #1;
    check("mr_regrant_s1", {62'd0, rready_s1, rready_s2}, 64'h2);
    check("mr_regrant_rdata", {32'd0, rdata_m}, 64'h4000);
    tick();
    clear_inputs();

    // Randomized traffic against the model and the scoreboard.
    apply_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_left[i]   = 0;
      r_bursts[i] = 30;
      b_cnt[i]    = 30;
      rv[i]       = 1'b0;
      bv[i]       = 1'b0;
      rid_c[i]    = '0;
      rd_c[i]     = '0;
      rr_c[i]     = '0;
      rl_c[i]     = 1'b0;
      bid_c[i]    = '0;
      br_c[i]     = '0;
      acc_r[i]    = 1'b0;
      acc_b[i]    = 1'b0;
    end
    drained = 1'b0;
    cyc     = 0;
    while (!drained && cyc < 4000) begin
      drive_random();
      tick();
      cyc++;
      drained = (r_bursts[0] == 0) && (r_bursts[1] == 0) && (r_left[0] == 0) &&
                (r_left[1] == 0) && !rv[0] && !rv[1] && (b_cnt[0] == 0) &&
                (b_cnt[1] == 0) && !bv[0] && !bv[1];
    end
    sb_en = 1'b0;
    check("rand_drained", {63'd0, drained}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      check("sb_r_count", 64'(rx_r[i].size()), 64'(gen_r[i].size()));
      for (int j = 0; j < gen_r[i].size() && j < rx_r[i].size(); j++)
        check("sb_r_beat", {25'd0, rx_r[i][j]}, {25'd0, gen_r[i][j]});
      check("sb_b_count", 64'(rx_b[i].size()), 64'(gen_b[i].size()));
      for (int j = 0; j < gen_b[i].size() && j < rx_b[i].size(); j++)
        check("sb_b_resp", {58'd0, rx_b[i][j]}, {58'd0, gen_b[i][j]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
